// File: rtl/conv_pkg.sv
// Shared constants, kernel and FSM state type for the 5x5 Gaussian filter.
package conv_pkg;

    localparam int unsigned KSUM_SHIFT = 8;
    localparam int unsigned ROUND      = 128;
    localparam int unsigned ACC_W      = 17;

    localparam int unsigned G [5] = '{1, 4, 6, 4, 1};

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    // Separable weight w(i,j) = g(i)*g(j) selected by flat tap index k = 5*i+j.
    function automatic logic [5:0] coef(input logic [4:0] k);
        logic [5:0] c;
        c = '0;
        for (int unsigned i = 0; i < 5; i++) begin
            for (int unsigned j = 0; j < 5; j++) begin
                if (k == 5'(5 * i + j)) begin
                    c = 6'(G[i] * G[j]);
                end
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/conv_mac.sv
// Coefficient lookup, multiply-accumulate and round/clamp for one output pixel.
module conv_mac
    import conv_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr_i,
    input  logic       acc_en_i,
    input  logic [4:0] k_i,
    input  logic [7:0] din_i,
    output logic [7:0] pix_o
);

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [ACC_W-1:0] prod;
    logic [ACC_W-1:0] sum;
    logic [ACC_W:0]   rounded;

    // pix_o reflects the sum including the tap being accumulated this cycle,
    // so the final pixel is available in the same cycle as the last tap.
    always_comb begin
        prod    = ACC_W'(din_i) * ACC_W'(coef(k_i));
        sum     = acc_q + prod;
        acc_d   = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (acc_en_i) begin
            acc_d = sum;
        end
        rounded = ({1'b0, sum} + (ACC_W + 1)'(ROUND)) >> KSUM_SHIFT;
        pix_o   = (rounded > (ACC_W + 1)'(255)) ? 8'hFF : rounded[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/conv5x5_filter.sv
// 5x5 Gaussian filter over a padded image BRAM, one output pixel per 27 cycles.
module conv5x5_filter
    import conv_pkg::*;
#(
    parameter int N   = 16,
    parameter int PAD = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        go,
    output logic        flag,
    output logic        busy,
    output logic        ena_pad,
    output logic [14:0] addr_pad,
    input  logic [7:0]  dout_pad,
    output logic        ena_out,
    output logic        wea_out,
    output logic [13:0] addr_out,
    output logic [7:0]  din_out
);

    localparam int          P        = N + 2 * PAD;
    localparam logic [13:0] LAST_PIX = 14'(N * N - 1);
    localparam logic [13:0] LAST_COL = 14'(N - 1);

    state_e      state_q;
    logic [4:0]  cnt_q;
    logic [2:0]  j_q;
    logic [13:0] c_q;
    logic [14:0] base_q;
    logic [14:0] addr_pad_q;
    logic [13:0] pix_q;
    logic        wea_q;
    logic [7:0]  din_q;
    logic        busy_q;
    logic        flag_q;
    logic        ena_pad_q;

    logic        mac_clr;
    logic        mac_en;
    logic [4:0]  mac_k;
    logic [7:0]  mac_pix;

    // Data for tap k arrives in period cycle k+1, hence the k-1 lookup.
    always_comb begin
        mac_clr = (state_q != S_RUN) || (cnt_q == 5'd0);
        mac_en  = (state_q == S_RUN) && (cnt_q >= 5'd1) && (cnt_q <= 5'd25);
        mac_k   = cnt_q - 5'd1;
    end

    conv_mac u_mac (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (mac_clr),
        .acc_en_i (mac_en),
        .k_i      (mac_k),
        .din_i    (dout_pad),
        .pix_o    (mac_pix)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            j_q        <= '0;
            c_q        <= '0;
            base_q     <= '0;
            addr_pad_q <= '0;
            pix_q      <= '0;
            wea_q      <= 1'b0;
            din_q      <= '0;
            busy_q     <= 1'b0;
            flag_q     <= 1'b0;
            ena_pad_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    wea_q <= 1'b0;
                    if (go) begin
                        state_q    <= S_RUN;
                        busy_q     <= 1'b1;
                        ena_pad_q  <= 1'b1;
                        flag_q     <= 1'b0;
                        cnt_q      <= '0;
                        j_q        <= '0;
                        c_q        <= '0;
                        base_q     <= '0;
                        addr_pad_q <= '0;
                        pix_q      <= '0;
                    end
                end
                S_RUN: begin
                    if (!go) begin
                        state_q   <= S_IDLE;
                        busy_q    <= 1'b0;
                        ena_pad_q <= 1'b0;
                        wea_q     <= 1'b0;
                    end else begin
                        wea_q <= (cnt_q == 5'd25);
                        if (cnt_q == 5'd25) begin
                            din_q <= mac_pix;
                        end
                        if (cnt_q == 5'd26) begin
                            cnt_q <= '0;
                            j_q   <= '0;
                            if (pix_q == LAST_PIX) begin
                                state_q   <= S_DONE;
                                busy_q    <= 1'b0;
                                ena_pad_q <= 1'b0;
                                flag_q    <= 1'b1;
                            end else begin
                                pix_q <= pix_q + 14'd1;
                                // Row wrap skips the right and left padding columns.
                                if (c_q == LAST_COL) begin
                                    c_q        <= '0;
                                    base_q     <= base_q + 15'(1 + 2 * PAD);
                                    addr_pad_q <= base_q + 15'(1 + 2 * PAD);
                                end else begin
                                    c_q        <= c_q + 14'd1;
                                    base_q     <= base_q + 15'd1;
                                    addr_pad_q <= base_q + 15'd1;
                                end
                            end
                        end else begin
                            cnt_q <= cnt_q + 5'd1;
                            if (cnt_q < 5'd24) begin
                                if (j_q == 3'd4) begin
                                    j_q        <= '0;
                                    addr_pad_q <= addr_pad_q + 15'(P - 4);
                                end else begin
                                    j_q        <= j_q + 3'd1;
                                    addr_pad_q <= addr_pad_q + 15'd1;
                                end
                            end
                        end
                    end
                end
                S_DONE: begin
                    wea_q <= 1'b0;
                    if (!go) begin
                        state_q <= S_IDLE;
                        flag_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    busy_q    <= 1'b0;
                    ena_pad_q <= 1'b0;
                    wea_q     <= 1'b0;
                    flag_q    <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        flag     = flag_q;
        busy     = busy_q;
        ena_pad  = ena_pad_q;
        addr_pad = addr_pad_q;
        ena_out  = 1'b1;
        wea_out  = wea_q;
        addr_out = pix_q;
        din_out  = din_q;
    end

endmodule

// File: tb/tb_conv5x5_filter.sv
// Randomised and directed checks of conv5x5_filter against a plain-arithmetic convolution model.
module tb_conv5x5_filter;

    localparam int N   = 16;
    localparam int PAD = 2;
    localparam int P   = N + 2 * PAD;

    logic        clk;
    logic        rst;
    logic        go;
    logic        flag;
    logic        busy;
    logic        ena_pad;
    logic [14:0] addr_pad;
    logic [7:0]  dout_pad;
    logic        ena_out;
    logic        wea_out;
    logic [13:0] addr_out;
    logic [7:0]  din_out;

    int n_checks;
    int n_fail;

    logic [7:0] img  [P*P];
    logic [7:0] outm [N*N];
    logic [7:0] prevm[N*N];
    int wr_count;
    int order_err;
    int busy_idx;
    int last_wr_idx;

    int gtb [5] = '{1, 4, 6, 4, 1};

    conv5x5_filter #(.N(N), .PAD(PAD)) dut (
        .clk      (clk),
        .rst      (rst),
        .go       (go),
        .flag     (flag),
        .busy     (busy),
        .ena_pad  (ena_pad),
        .addr_pad (addr_pad),
        .dout_pad (dout_pad),
        .ena_out  (ena_out),
        .wea_out  (wea_out),
        .addr_out (addr_out),
        .din_out  (din_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ena_pad) dout_pad <= img[addr_pad];
    end

    always @(negedge clk) begin
        if (wea_out) begin
            if (int'(addr_out) != wr_count) order_err++;
            if (int'(addr_out) < N*N) outm[addr_out] = din_out;
            wr_count++;
            last_wr_idx = busy_idx;
        end
        if (busy) busy_idx++;
    end

    function automatic int expect_px(input int r, input int c);
        int s;
        int v;
        s = 0;
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++)
                s += gtb[i] * gtb[j] * int'(img[(r + i) * P + (c + j)]);
        v = (s + 128) / 256;
        if (v > 255) v = 255;
        return v;
    endfunction

    function automatic int count_bad(input int lo, input int hi);
        int n;
        n = 0;
        for (int p = lo; p <= hi; p++)
            if (outm[p] !== 8'(expect_px(p / N, p % N))) n++;
        return n;
    endfunction

    // mode 0: 100 interior, 1: impulse at (8,8), 2: 255 interior, 3: fully random
    task automatic fill_image(input int mode);
        for (int p = 0; p < P*P; p++) begin
            int r;
            int c;
            r = p / P;
            c = p % P;
            img[p] = 8'd0;
            if (mode == 3) img[p] = 8'($urandom_range(0, 255));
            else if (r >= PAD && r < PAD + N && c >= PAD && c < PAD + N) begin
                if (mode == 0) img[p] = 8'd100;
                if (mode == 2) img[p] = 8'd255;
            end
        end
        if (mode == 1) img[(8 + PAD) * P + (8 + PAD)] = 8'd255;
    endtask

    task automatic clear_log();
        wr_count    = 0;
        order_err   = 0;
        busy_idx    = 0;
        last_wr_idx = -1;
        for (int p = 0; p < N*N; p++) outm[p] = 8'h00;
    endtask

    task automatic run_image(output bit timed_out);
        go = 1'b1;
        timed_out = 1'b1;
        for (int i = 0; i < 8000; i++) begin
            @(negedge clk);
            if (flag) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic idle(input int n);
        go = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        n_checks++; if (flag !== 1'b0) begin n_fail++; $display("FAIL reset_flag: got %b required 0", flag); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", busy); end
        n_checks++; if (ena_pad !== 1'b0) begin n_fail++; $display("FAIL reset_ena_pad: got %b required 0", ena_pad); end
        n_checks++; if (wea_out !== 1'b0) begin n_fail++; $display("FAIL reset_wea: got %b required 0", wea_out); end
        n_checks++; if (addr_pad !== 15'd0) begin n_fail++; $display("FAIL reset_addr_pad: got %0d required 0", addr_pad); end
        n_checks++; if (addr_out !== 14'd0) begin n_fail++; $display("FAIL reset_addr_out: got %0d required 0", addr_out); end
        n_checks++; if (din_out !== 8'd0) begin n_fail++; $display("FAIL reset_din: got %0d required 0", din_out); end
        n_checks++; if (ena_out !== 1'b1) begin n_fail++; $display("FAIL reset_ena_out: got %b required 1", ena_out); end
    endtask

    task automatic test_constant();
        bit to;
        int bad;
        idle(2);
        fill_image(0);
        clear_log();
        run_image(to);
        n_checks++; if (to) begin n_fail++; $display("FAIL const_timeout: flag got 0 required 1"); end
        n_checks++; if (busy_idx != N*N*27) begin n_fail++; $display("FAIL const_cycles: got %0d required %0d", busy_idx, N*N*27); end
        n_checks++; if (last_wr_idx != N*N*27 - 1) begin n_fail++; $display("FAIL const_last_write: got %0d required %0d", last_wr_idx, N*N*27 - 1); end
        n_checks++; if (wr_count != N*N || order_err != 0) begin n_fail++; $display("FAIL const_writes: count %0d order errors %0d required %0d/0", wr_count, order_err, N*N); end
        n_checks++; if (outm[8*N+8] !== 8'd100) begin n_fail++; $display("FAIL const_center: got %0d required 100", outm[8*N+8]); end
        n_checks++; if (outm[0] !== 8'd47) begin n_fail++; $display("FAIL const_corner: got %0d required 47", outm[0]); end
        bad = count_bad(0, N*N - 1);
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL const_image: bad pixels %0d required 0", bad); end
        idle(2);
        n_checks++; if (flag !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL const_back_idle: flag %b busy %b required 0/0", flag, busy); end
    endtask

    task automatic test_impulse();
        bit to;
        int bad;
        idle(2);
        fill_image(1);
        clear_log();
        run_image(to);
        n_checks++; if (to || wr_count != N*N) begin n_fail++; $display("FAIL imp_run: timeout %b writes %0d required 0/%0d", to, wr_count, N*N); end
        n_checks++; if (outm[8*N+8] !== 8'd36) begin n_fail++; $display("FAIL imp_center: got %0d required 36", outm[8*N+8]); end
        n_checks++; if (outm[8*N+9] !== 8'd24) begin n_fail++; $display("FAIL imp_side: got %0d required 24", outm[8*N+9]); end
        n_checks++; if (outm[6*N+6] !== 8'd1) begin n_fail++; $display("FAIL imp_corner: got %0d required 1", outm[6*N+6]); end
        n_checks++; if (outm[5*N+5] !== 8'd0) begin n_fail++; $display("FAIL imp_outside: got %0d required 0", outm[5*N+5]); end
        bad = count_bad(0, N*N - 1);
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL imp_image: bad pixels %0d required 0", bad); end
    endtask

    task automatic test_all255();
        bit to;
        int bad;
        idle(2);
        fill_image(2);
        clear_log();
        run_image(to);
        n_checks++; if (to || wr_count != N*N) begin n_fail++; $display("FAIL sat_run: timeout %b writes %0d required 0/%0d", to, wr_count, N*N); end
        n_checks++; if (outm[8*N+8] !== 8'd255) begin n_fail++; $display("FAIL sat_center: got %0d required 255", outm[8*N+8]); end
        bad = count_bad(0, N*N - 1);
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL sat_image: bad pixels %0d required 0", bad); end
    endtask

    task automatic test_random();
        bit to;
        int bad;
        idle(2);
        fill_image(3);
        clear_log();
        run_image(to);
        bad = count_bad(0, N*N - 1);
        n_checks++; if (to || wr_count != N*N || order_err != 0) begin n_fail++; $display("FAIL rand_run: timeout %b writes %0d order %0d", to, wr_count, order_err); end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL rand_image: bad pixels %0d required 0", bad); end
    endtask

    task automatic test_done_hold();
        bit to;
        int bad;
        int saved;
        idle(2);
        fill_image(3);
        clear_log();
        run_image(to);
        saved = wr_count;
        repeat (100) @(negedge clk);
        n_checks++; if (flag !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL hold_flag: flag %b busy %b required 1/0", flag, busy); end
        n_checks++; if (wr_count != saved || saved != N*N) begin n_fail++; $display("FAIL hold_writes: got %0d (was %0d) required %0d", wr_count, saved, N*N); end
        for (int p = 0; p < N*N; p++) prevm[p] = outm[p];
        go = 1'b0;
        @(negedge clk);
        n_checks++; if (flag !== 1'b0) begin n_fail++; $display("FAIL hold_drop: flag got %b required 0", flag); end
        clear_log();
        run_image(to);
        bad = 0;
        for (int p = 0; p < N*N; p++) if (outm[p] !== prevm[p]) bad++;
        n_checks++; if (to || bad != 0 || wr_count != N*N) begin n_fail++; $display("FAIL hold_rerun: timeout %b differing %0d writes %0d", to, bad, wr_count); end
        bad = count_bad(0, N*N - 1);
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL hold_image: bad pixels %0d required 0", bad); end
    endtask

    task automatic test_abort();
        bit seen;
        int bad;
        idle(2);
        fill_image(3);
        clear_log();
        go = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (busy) begin seen = 1'b1; break; end
        end
        n_checks++; if (!seen) begin n_fail++; $display("FAIL abort_start: busy got 0 required 1"); end
        repeat (5 * 27 + 10) @(negedge clk);
        go = 1'b0;
        repeat (40) @(negedge clk);
        n_checks++; if (wr_count != 5 || order_err != 0) begin n_fail++; $display("FAIL abort_writes: got %0d order %0d required 5/0", wr_count, order_err); end
        n_checks++; if (flag !== 1'b0 || busy !== 1'b0 || ena_pad !== 1'b0) begin n_fail++; $display("FAIL abort_idle: flag %b busy %b ena_pad %b required 0", flag, busy, ena_pad); end
        bad = count_bad(0, 4);
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL abort_data: bad pixels %0d required 0", bad); end
    endtask

    task automatic test_rst_mid();
        bit to;
        int bad;
        idle(2);
        fill_image(3);
        clear_log();
        go = 1'b1;
        repeat (100) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (flag !== 1'b0 || busy !== 1'b0 || ena_pad !== 1'b0 || wea_out !== 1'b0) begin n_fail++; $display("FAIL rst_ctrl: flag %b busy %b ena_pad %b wea %b required 0", flag, busy, ena_pad, wea_out); end
        n_checks++; if (addr_pad !== 15'd0 || addr_out !== 14'd0 || din_out !== 8'd0) begin n_fail++; $display("FAIL rst_data: addr_pad %0d addr_out %0d din %0d required 0", addr_pad, addr_out, din_out); end
        repeat (3) @(negedge clk);
        clear_log();
        rst = 1'b0;
        run_image(to);
        n_checks++; if (to || wr_count != N*N || order_err != 0) begin n_fail++; $display("FAIL rst_rerun: timeout %b writes %0d order %0d", to, wr_count, order_err); end
        bad = count_bad(0, N*N - 1);
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL rst_image: bad pixels %0d required 0", bad); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        go       = 1'b0;
        fill_image(0);
        clear_log();
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b0;
        test_constant();
        test_impulse();
        test_all255();
        test_random();
        test_done_hold();
        test_abort();
        test_rst_mid();
        go = 1'b0;
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
